// File: rtl/ycbcr_to_rgb.sv
//==============================================================================
// Module   : ycbcr_to_rgb
// Purpose  : Inverse BT.601 full-swing YCbCr -> RGB, 8.8 fixed point,
//            3-stage valid/ready pipeline with output clamping.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module ycbcr_to_rgb #(
  parameter int ROUND = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] Y,
  input  logic [7:0] Cb,
  input  logic [7:0] Cr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
);

  // 18 bits signed covers the largest product magnitude (454*128 = 58112)
  // and every sum formed from it, so nothing wraps.
  localparam int W = 18;
  localparam logic signed [W-1:0] RND   = (ROUND != 0) ? 18'sd128 : 18'sd0;
  localparam logic signed [W-1:0] K_RCR = 18'sd359;
  localparam logic signed [W-1:0] K_GCB = 18'sd88;
  localparam logic signed [W-1:0] K_GCR = 18'sd183;
  localparam logic signed [W-1:0] K_BCB = 18'sd454;

  logic                advance;
  logic signed [W-1:0] cb_ext;
  logic signed [W-1:0] cr_ext;

  // Stage 1: products and luma
  logic                s1_valid;
  logic [7:0]          s1_y;
  logic signed [W-1:0] s1_r_prod;
  logic signed [W-1:0] s1_g_cb_prod;
  logic signed [W-1:0] s1_g_cr_prod;
  logic signed [W-1:0] s1_b_prod;

  // Stage 2: unclamped signed channel sums
  logic                s2_valid;
  logic signed [W-1:0] s2_r;
  logic signed [W-1:0] s2_g;
  logic signed [W-1:0] s2_b;

  logic signed [W-1:0] y_ext;
  logic signed [W-1:0] r_sum;
  logic signed [W-1:0] g_sum;
  logic signed [W-1:0] b_sum;

  // The whole pipe moves together; a full pipe stalls only when the sink is
  // not taking the head sample.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign cb_ext = {{10{Cb[7]}}, Cb};
  assign cr_ext = {{10{Cr[7]}}, Cr};
  assign y_ext  = {10'd0, s1_y};

  // Rounding constant is added before each shift independently, so G rounds
  // once on the combined chroma term rather than per product.
  assign r_sum = y_ext + ((s1_r_prod + RND) >>> 8);
  assign g_sum = y_ext - ((s1_g_cb_prod + s1_g_cr_prod + RND) >>> 8);
  assign b_sum = y_ext + ((s1_b_prod + RND) >>> 8);

  function automatic logic [7:0] clamp8(input logic signed [W-1:0] v);
    if (v[W-1])
      clamp8 = 8'd0;
    else if (v > 18'sd255)
      clamp8 = 8'hFF;
    else
      clamp8 = v[7:0];
  endfunction

  // Stage 1: register chroma products and luma for accepted samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_y         <= 8'd0;
      s1_r_prod    <= '0;
      s1_g_cb_prod <= '0;
      s1_g_cr_prod <= '0;
      s1_b_prod    <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_y         <= Y;
        s1_r_prod    <= cr_ext * K_RCR;
        s1_g_cb_prod <= cb_ext * K_GCB;
        s1_g_cr_prod <= cr_ext * K_GCR;
        s1_b_prod    <= cb_ext * K_BCB;
      end
    end
  end

  // Stage 2: register the scaled, luma-offset channel sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_r <= r_sum;
        s2_g <= g_sum;
        s2_b <= b_sum;
      end
    end
  end

  // Stage 3: clamp to 0..255 and present the result with its valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      R         <= 8'd0;
      G         <= 8'd0;
      B         <= 8'd0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        R <= clamp8(s2_r);
        G <= clamp8(s2_g);
        B <= clamp8(s2_b);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ycbcr_to_rgb.md
YCBCR_TO_RGB -- requirements
Module: ycbcr_to_rgb

Interface
REQ-001 SHALL have parameter ROUND, default 0; 0 = floor (arithmetic right shift), 1 = add 128 before each >>>8 (round half up).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  input sample valid.
REQ-005 SHALL have port in_ready  output  1  block accepts the input sample this cycle.
REQ-006 SHALL have port Y  input  8  luma, unsigned 0..255.
REQ-007 SHALL have port Cb  input  8  blue-difference chroma, signed two's complement -128..127.
REQ-008 SHALL have port Cr  input  8  red-difference chroma, signed two's complement -128..127.
REQ-009 SHALL have port out_valid  output  1  RGB sample valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the RGB sample this cycle.
REQ-011 SHALL have ports R, G, B  output  8 each  unsigned RGB result.

Function
REQ-012 SHALL implement inverse BT.601 full swing in 8.8 fixed point: R = Y + (359*Cr >>> 8); G = Y - ((88*Cb + 183*Cr) >>> 8); B = Y + (454*Cb >>> 8).
REQ-013 SHALL use signed intermediates of at least 18 bits, with Y zero-extended, so that no product or sum overflows.
REQ-014 SHALL clamp each of R, G, B to 0..255: negative results give 0; results above 255 give 255.
REQ-015 SHALL use a 3-stage pipeline: S1 registers the products and Y; S2 registers the signed sums; S3 registers the clamped RGB and out_valid.
REQ-016 SHALL have a latency of 3 clk edges from acceptance (in_valid & in_ready) to out_valid when out_ready is held high.
REQ-017 SHALL sustain a throughput of 1 sample per clock when out_ready=1.
REQ-018 SHALL carry a valid bit with each stage; a bubble (in_valid=0 on an accepted cycle) SHALL propagate as an invalid stage and SHALL NOT produce out_valid.
REQ-019 SHALL define advance = !out_valid | out_ready; all stages SHALL shift only when advance=1 and SHALL hold contents and valid bits when advance=0.
REQ-020 SHALL drive in_ready = advance combinationally; in_ready SHALL NOT depend on in_valid.
REQ-021 SHALL keep R, G, B and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL transfer an output sample exactly once, on the cycle where out_valid & out_ready.
REQ-023 SHALL ignore Y, Cb and Cr on cycles where in_valid=0 or in_ready=0.
REQ-024 SHALL, when out_ready rises after a stall with all 3 stages full, emit one sample per clock in order and accept a new input on the same cycle.

Reset
REQ-025 SHALL, while rst_n=0, immediately clear all stage valid bits and drive out_valid=0, R=G=B=0, independent of clk.
REQ-026 SHALL drop samples in flight when reset is asserted mid-stream; the first out_valid after reset SHALL come from an input accepted after rst_n deasserts.
REQ-027 SHALL drive in_ready=1 during and after reset, because out_valid=0 makes advance=1.

Verification
REQ-028 SHALL cover: Y=128, Cb=0, Cr=0, out_ready=1 -> R=G=B=128 exactly 3 cycles later.
REQ-029 SHALL cover: Y=255, Cb=0, Cr=127, ROUND=0 -> R=255 (433 clamped), G=165, B=255; with ROUND=1 -> G=164.
REQ-030 SHALL cover: Y=0, Cb=-128, Cr=0 -> R=0, G=44, B=0 (-227 clamped).
REQ-031 SHALL cover: continuous stream of 8 distinct samples with out_ready low for 5 cycles mid-stream -> in_ready low during the stall, outputs held, all 8 results in order with no loss and no duplicates.
REQ-032 SHALL cover: in_valid toggled 1,0,1,0 -> exactly 2 out_valid pulses, separated by one idle cycle.
REQ-033 SHALL cover: rst_n pulsed low asynchronously (between clk edges) with 3 samples in flight -> out_valid=0 immediately and none of those 3 samples is ever output.
